// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states, bit timing
// and the default per-frame timeout.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT           = 10417;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 131071;
    localparam int unsigned TIMEOUT_W              = 17;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitLow,
        StWaitHigh
    } arb_state_e;

    // Round-robin successor of an index, wrapping at n.
    function automatic logic [2:0] next_index(input logic [2:0] idx, input int unsigned n);
        return (idx == 3'(n - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, searching upward modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         index,
    output logic               found
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [3:0] pos;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(NUM_REQ)) begin
                pos = pos - 4'(NUM_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                  = 1'b1;
                grant[pos[IDX_W-1:0]]  = 1'b1;
                index                  = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers with round-robin fairness
// and a per-frame timeout guarding against a stuck transmitter.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 err,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e           state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [2:0]           pick_idx;
    logic                 pick_found;
    logic [7:0]           pick_byte;
    logic [NUM_REQ-1:0]   owner_mask;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic                 tmo_hit;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .grant(pick_grant),
        .index(pick_idx),
        .found(pick_found)
    );

    always_comb begin
        pick_byte = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) begin
                pick_byte = req_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        owner_mask = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            owner_mask[k] = (grant_id_q == 3'(k));
        end
    end

    assign tmo_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TIMEOUT_W'(1);
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        req_done   = '0;
        err        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    tx_data_d  = pick_byte;
                    tx_start_d = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                tmo_cnt_d = '0;
                state_d   = StWaitLow;
            end
            // tx_done may still be high from the previous frame until uart_tx
            // accepts this start; wait for it to drop before looking for the rise.
            StWaitLow: begin
                tmo_cnt_d = tmo_inc;
                if (tmo_hit) begin
                    err      = 1'b1;
                    rr_ptr_d = next_index(grant_id_q, NUM_REQ);
                    state_d  = StIdle;
                end else if (!tx_done) begin
                    state_d = StWaitHigh;
                end
            end
            // Completion takes priority over a coincident timeout.
            StWaitHigh: begin
                tmo_cnt_d = tmo_inc;
                if (tx_done) begin
                    req_done = owner_mask;
                    rr_ptr_d = next_index(grant_id_q, NUM_REQ);
                    state_d  = StIdle;
                end else if (tmo_hit) begin
                    err      = 1'b1;
                    rr_ptr_d = next_index(grant_id_q, NUM_REQ);
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign req_ready = (state_q == StIdle) ? pick_grant : '0;
    assign busy      = (state_q != StIdle);
    assign grant_id  = grant_id_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one uart_tx (range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 131071, SHALL set the maximum number of cycles allowed per frame from tx_start to the tx_done rise.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  SHALL carry per-requester byte-valid; requester i holds it high until accepted.
REQ-006 req_data  input  8*NUM_REQ  SHALL carry the byte of requester i on bits [8i+7:8i].
REQ-007 req_ready  output  NUM_REQ  SHALL be one-hot or zero; a byte transfers on an edge where req_valid[i] and req_ready[i] are both high.
REQ-008 req_done  output  NUM_REQ  SHALL pulse one cycle on bit i when requester i's frame completes.
REQ-009 err  output  1  SHALL pulse one cycle on a frame timeout.
REQ-010 grant_id  output  3  SHALL hold the index of the current or last owner.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 tx_start  output  1  SHALL be the registered start strobe to uart_tx.
REQ-013 tx_data  output  8  SHALL be the registered byte to uart_tx, stable from tx_start until the frame ends.
REQ-014 tx_done  input  1  SHALL be the uart_tx done level: set at end of stop bit, cleared when the next start is accepted.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, START, WAIT_LOW and WAIT_HIGH.
REQ-016 In IDLE, req_ready SHALL combinationally grant the first asserted req_valid at or after rr_ptr, searching upward modulo NUM_REQ; otherwise req_ready SHALL be zero.
REQ-017 On a handshake in IDLE: capture req_data slice into tx_data, set grant_id, assert tx_start next cycle, go START.
REQ-018 START SHALL last exactly one cycle (tx_start high only here), clear timeout counter, go WAIT_LOW.
REQ-019 WAIT_LOW SHALL wait until tx_done==0, then go WAIT_HIGH; this consumes a stale tx_done high left from the prior frame.
REQ-020 WAIT_HIGH SHALL wait until tx_done==1, then pulse req_done[grant_id], set rr_ptr=(grant_id+1) mod NUM_REQ, go IDLE.
REQ-021 Timeout counter (17 bits, saturating) SHALL increment each cycle in WAIT_LOW/WAIT_HIGH.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1: pulse err, no req_done, advance rr_ptr as in REQ-020, go IDLE.
REQ-023 Timeout and tx_done rise SHALL NOT be double-counted; if both occur on the same cycle in WAIT_HIGH, completion wins and err stays low.
REQ-024 Latency SHALL be: handshake edge N, tx_start high cycle N+1; minimum gap from req_done to next tx_start is 2 cycles.
REQ-025 A requester dropping req_valid before handshake SHALL cause no transfer and no state change.
REQ-026 req_valid changes outside IDLE SHALL be ignored; no grant is issued while busy.
REQ-027 rr_ptr wrap: after grant to NUM_REQ-1, the next search SHALL start at 0.

Reset
REQ-028 Reset SHALL force: state IDLE, rr_ptr 0, grant_id 0, tx_start 0, tx_data 0x00, req_done 0, err 0, timeout counter 0.
REQ-029 Reset mid-frame SHALL abandon the frame without req_done or err; the owner re-requests.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum, CLKS_PER_BIT (10417) and default TIMEOUT_CYCLES.
REQ-031 The round-robin picker SHALL be a combinational sub-module rr_arbiter (inputs req and ptr, output one-hot grant and index).

Verification (bench uses uart_tx with CLKS_PER_BIT=4, TIMEOUT_CYCLES=200)
REQ-032 Single request: req_valid=0001, data 0xA5 -> tx_start one cycle after handshake; serial 0,1,0,1,0,0,1,0,1,1; req_done=0001 once.
REQ-033 Fairness: all four valid continuously with bytes 0x10..0x13 -> grant order 0,1,2,3,0 and bytes serialized in that order.
REQ-034 Back-to-back: requester 2 sends 0x55 then 0xAA -> second tx_start occurs only after tx_done falls/rises; both frames intact.
REQ-035 Timeout: tx_done held 0 by stub -> err pulses 200 cycles after START; no req_done; next grant goes to the next index.
REQ-036 Reset asserted mid-data-bit -> busy 0, tx_start 0 immediately; no req_done; next request served normally from rr_ptr 0.
